hdmi_status_sb_tx: RTL and testbench
====================================

# hdmi_status_sb_tx

Producer end of the HDMI status sideband AXI-Stream. It samples asynchronous link status inputs from the HDMI PHY/bridge: link ready and hot-plug detect. It synchronises and debounces them, then emits 2-bit status beats on `status_sb_tdata`/`status_sb_tvalid` with full `tready` backpressure. A beat is sent after reset, on every debounced change, and on an optional periodic refresh. Downstream consumers such as the heartbeat LED logic treat `status_sb_tdata[0]` as link ready.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser flops per input, minimum 2.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required before the debounced value changes, minimum 1.
- `REFRESH_CYCLES`, 10_000_000: re-send period in cycles after each accepted beat; 0 disables refresh. Held in a 32-bit counter.

Ports:
- `status_sb_aclk`  in  1  sole clock; all logic is on its rising edge.
- `status_sb_areset`  in  1  reset, asynchronous, active-high.
- `link_rdy_in`  in  1  link ready, asynchronous to `status_sb_aclk`.
- `hpd_in`  in  1  hot-plug detect, asynchronous to `status_sb_aclk`.
- `status_sb_tdata`  out  2  bit0 = link ready, bit1 = HPD.
- `status_sb_tvalid`  out  1  beat valid.
- `status_sb_tready`  in  1  consumer accepts.
- `status_cur`  out  2  debounced status, same bit map as `tdata`.
- `tx_count`  out  16  accepted-beat counter, wraps at 0xFFFF to 0.

## Operation
- **Reset values:** all synchroniser flops, debounced bits, `last_sent`, `tdata`, `tvalid`, `tx_count` and the refresh counter are 0. The force-send flag is 1. State is IDLE.
- **Synchroniser:** each input passes through a `SYNC_STAGES` flop chain.
- **Debounce, per bit, independent:**
  - A counter increments each cycle that the synced value differs from the debounced value.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced bit takes the synced value on that edge and the counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` cycles are never reported.
- **TX FSM, IDLE:**
  - A send is requested if any of these holds: force flag = 1, `status_cur` != `last_sent`, or refresh request = 1.
  - On a request: `tdata` <= `status_cur`, `tvalid` <= 1, clear the force flag and the refresh request, go to SEND.
  - Several simultaneous request causes produce exactly one beat.
- **TX FSM, SEND:**
  - `tdata` and `tvalid` are held constant; `status_cur` changes during SEND are not reflected in the current beat.
  - On `tvalid & tready`: `last_sent` <= `tdata`, `tvalid` <= 0, `tx_count` += 1, refresh counter <= 0, go to IDLE.
  - Consequence: a change that arrived during SEND is sent as a new beat once IDLE re-evaluates.
  - A debounced bit that toggles and returns before acceptance produces no extra beat, because `status_cur` equals `last_sent` again.
- **Refresh:**
  - With `REFRESH_CYCLES` > 0, the counter increments every cycle in IDLE and in SEND.
  - It sets the refresh request when it reaches `REFRESH_CYCLES`.
  - It saturates there until the request is consumed.
- **Reset during operation:**
  - `tvalid` drops immediately, which is an allowed sideband abort.
  - After release, an initial beat is sent, with `tdata` = `status_cur` = 00.

## Timing
- **First beat after reset:** `tvalid`=1, `tdata`=00 from the first rising edge after reset deassertion.
- **Input to `status_cur`:** `SYNC_STAGES` + `DEBOUNCE_CYCLES` edges after the input settles.
- **`status_cur` to `tvalid`:** IDLE asserts `tvalid` on the edge after `status_cur` changes (1 cycle).
- **Gap between beats:**
  - After acceptance, `tvalid` is low for exactly one cycle (the IDLE evaluation) before the next beat.
  - Maximum throughput is one beat per 2 cycles.
- **`tready` behaviour:**
  - `tready` may be held high permanently.
  - `tvalid` never depends combinationally on `tready`.
- **Refresh spacing:** with no changes, consecutive `tvalid` rises are `REFRESH_CYCLES` + 1 cycles apart when `tready`=1.

## Test plan
Settings: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `REFRESH_CYCLES`=0 unless noted.
- **Reset release:** release reset, `tready`=1, inputs 0 -> one beat `tdata`=00, `tx_count`=1, then `tvalid` stays 0 for 100 cycles.
- **Clean change:** raise `link_rdy_in` and hold -> `status_cur`=01 exactly 6 edges later, `tvalid` with `tdata`=01 on the 7th, `tx_count`=2.
- **Glitch rejection:** 3-cycle `hpd_in` pulse -> `status_cur` unchanged, no beat; 4-cycle pulse -> two beats, 10 then 00 (with `link_rdy` 0).
- **Backpressure:** `tready`=0 for 50 cycles while `hpd_in` rises mid-beat -> `tdata`=01 held stable throughout; after acceptance, one idle cycle, then beat 11.
- **Refresh:** `REFRESH_CYCLES`=20, stable inputs, `tready`=1 -> beats repeat every 21 cycles with identical `tdata`; a change coinciding with refresh expiry gives one beat only.
- **Reset mid-beat:** assert reset with `tvalid`=1 and `tready`=0 -> `tvalid`, `tdata`, `tx_count` = 0 immediately; after release, beat 00, then the debounced input values are re-reported.

Source files
------------

// File: rtl/hdmi_status_sb_tx.sv
// rtl/hdmi_status_sb_tx.sv - HDMI status sideband AXI-Stream producer
//
// Synchronises and debounces the link-ready and hot-plug-detect inputs and
// sends a 2-bit status beat after reset, on every debounced change, and on
// an optional periodic refresh.
//
// Ports:
//   status_sb_aclk    in   sole clock, rising edge
//   status_sb_areset  in   asynchronous active-high reset
//   link_rdy_in       in   link ready, asynchronous
//   hpd_in            in   hot-plug detect, asynchronous
//   status_sb_tdata   out  [1:0] bit0 = link ready, bit1 = HPD
//   status_sb_tvalid  out  beat valid
//   status_sb_tready  in   consumer accepts
//   status_cur        out  [1:0] debounced status, same bit map as tdata
//   tx_count          out  [15:0] accepted-beat counter, wraps
module hdmi_status_sb_tx #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REFRESH_CYCLES  = 10_000_000
) (
  input  logic        status_sb_aclk,
  input  logic        status_sb_areset,
  input  logic        link_rdy_in,
  input  logic        hpd_in,
  output logic [1:0]  status_sb_tdata,
  output logic        status_sb_tvalid,
  input  logic        status_sb_tready,
  output logic [1:0]  status_cur,
  output logic [15:0] tx_count
);

  // The debounce counter never holds DEBOUNCE_CYCLES itself: it clears on
  // the edge it would get there, so it only needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     REFRESH_MAX = 32'(REFRESH_CYCLES);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  // ---------------------------------------------------------------------
  // Synchroniser and debounce (bit0 = link ready, bit1 = HPD)
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic [1:0]                  deb_q, deb_d;
  logic [1:0]                  synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = {hpd_in, link_rdy_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (synced[b] != deb_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          deb_d[b] = synced[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge status_sb_aclk or posedge status_sb_areset) begin
    if (status_sb_areset) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      deb_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      deb_q    <= deb_d;
    end
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [1:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic [1:0]  last_sent_q, last_sent_d;
  logic        force_q, force_d;
  logic [15:0] tx_count_q, tx_count_d;
  logic [31:0] refresh_cnt_q, refresh_cnt_d;
  logic        refresh_req_q, refresh_req_d;

  logic [31:0] refresh_inc;
  logic        refresh_hit;
  logic        refresh_due;
  logic        send_req;
  logic        accept;

  // refresh_hit fires only on the edge the counter arrives at the limit, so
  // a saturated counter does not re-arm the request while a beat is in flight.
  // Treating the arrival edge as a request is what gives REFRESH_CYCLES+1
  // spacing between refresh beats.
  assign refresh_inc = refresh_cnt_q + 32'd1;
  assign refresh_hit = (REFRESH_MAX != 32'd0) && (refresh_cnt_q != REFRESH_MAX) &&
                       (refresh_inc == REFRESH_MAX);
  assign refresh_due = refresh_req_q | refresh_hit;
  assign send_req    = force_q | (deb_q != last_sent_q) | refresh_due;
  assign accept      = tvalid_q & status_sb_tready;

  // State register
  always_ff @(posedge status_sb_aclk or posedge status_sb_areset) begin
    if (status_sb_areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (send_req) state_d = ST_SEND;
      ST_SEND: if (accept)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    last_sent_d   = last_sent_q;
    force_d       = force_q;
    tx_count_d    = tx_count_q;
    refresh_req_d = refresh_due;
    refresh_cnt_d = refresh_cnt_q;

    if ((REFRESH_MAX != 32'd0) && (refresh_cnt_q != REFRESH_MAX)) begin
      refresh_cnt_d = refresh_inc;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Any mix of causes collapses into this single beat.
        if (send_req) begin
          tdata_d       = deb_q;
          tvalid_d      = 1'b1;
          force_d       = 1'b0;
          refresh_req_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (accept) begin
          last_sent_d   = tdata_q;
          tvalid_d      = 1'b0;
          tx_count_d    = tx_count_q + 16'd1;
          refresh_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge status_sb_aclk or posedge status_sb_areset) begin
    if (status_sb_areset) begin
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      last_sent_q   <= '0;
      force_q       <= 1'b1;
      tx_count_q    <= '0;
      refresh_cnt_q <= '0;
      refresh_req_q <= 1'b0;
    end else begin
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      last_sent_q   <= last_sent_d;
      force_q       <= force_d;
      tx_count_q    <= tx_count_d;
      refresh_cnt_q <= refresh_cnt_d;
      refresh_req_q <= refresh_req_d;
    end
  end

  assign status_sb_tdata  = tdata_q;
  assign status_sb_tvalid = tvalid_q;
  assign status_cur       = deb_q;
  assign tx_count         = tx_count_q;

endmodule

// File: tb/tb_hdmi_status_sb_tx.sv
// tb/tb_hdmi_status_sb_tx.sv - scoreboard bench for hdmi_status_sb_tx
`timescale 1ns/1ps
module tb_hdmi_status_sb_tx;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int REFR = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link_in = 1'b0;
  logic        hpd_in = 1'b0;
  logic        tready = 1'b1;
  logic [1:0]  tdata0, cur0, tdata1, cur1;
  logic        tvalid0, tvalid1;
  logic [15:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hdmi_status_sb_tx #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(0)) dut0 (
    .status_sb_aclk  (clk),
    .status_sb_areset(rst),
    .link_rdy_in     (link_in),
    .hpd_in          (hpd_in),
    .status_sb_tdata (tdata0),
    .status_sb_tvalid(tvalid0),
    .status_sb_tready(tready),
    .status_cur      (cur0),
    .tx_count        (cnt0)
  );

  hdmi_status_sb_tx #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(REFR)) dut1 (
    .status_sb_aclk  (clk),
    .status_sb_areset(rst),
    .link_rdy_in     (link_in),
    .hpd_in          (hpd_in),
    .status_sb_tdata (tdata1),
    .status_sb_tvalid(tvalid1),
    .status_sb_tready(1'b1),
    .status_cur      (cur1),
    .tx_count        (cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the debounced bit flips once the last DB synchroniser
  // outputs all disagree with it; a beat is owed whenever the link is idle and
  // the status differs from the last accepted value (or after reset).
  logic [1:0]  hist [SYNC+DB];   // hist[k]: inputs seen k+1 edges ago
  logic [1:0]  m_status, m_last, m_data;
  logic        m_valid, m_force;
  logic [15:0] m_count;
  logic [1:0]  exp_q [$];
  bit          all_diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC+DB; k++) hist[k] = 2'b00;
      m_status = 2'b00; m_last = 2'b00; m_data = 2'b00;
      m_valid = 1'b0; m_force = 1'b1; m_count = 16'd0;
      exp_q.delete();
    end else begin
      if (m_valid) begin
        if (tready) begin
          m_valid = 1'b0;
          m_last  = m_data;
          m_count = m_count + 16'd1;
        end
      end else if (m_force || (m_status != m_last)) begin
        m_valid = 1'b1;
        m_data  = m_status;
        m_force = 1'b0;
        exp_q.push_back(m_status);
      end
      for (int b = 0; b < 2; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (hist[SYNC-1+j][b] == m_status[b]) all_diff = 1'b0;
        if (all_diff) m_status[b] = ~m_status[b];
      end
      for (int k = SYNC+DB-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {hpd_in, link_in};
    end
  end

  // Monitor for dut0: pops an expected beat at every tvalid rise and holds it
  // against tdata for the life of the beat.
  logic       prev_v;
  logic       have_exp;
  logic [1:0] cur_exp;
  initial begin
    prev_v = 1'b0;
    have_exp = 1'b0;
    cur_exp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev_v = 1'b0;
        have_exp = 1'b0;
      end else begin
        check("cycle_valid_status_count", 32'({tvalid0, cur0, cnt0}),
              32'({m_valid, m_status, m_count}));
        if (tvalid0 && !prev_v) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            have_exp = 1'b0;
            $display("FAIL unexpected_beat: got tdata %0h, expected no beat (t=%0t)", tdata0, $time);
          end else begin
            cur_exp = exp_q.pop_front();
            have_exp = 1'b1;
          end
        end
        if (tvalid0 && have_exp) check("beat_tdata", 32'(tdata0), 32'(cur_exp));
        prev_v = tvalid0;
      end
    end
  end

  // dut1 (refresh enabled, tready tied high): record every beat start.
  int         rise_t [$];
  logic [1:0] rise_d [$];
  logic       prev1;
  initial begin
    prev1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) prev1 = 1'b0;
      else begin
        if (tvalid1 && !prev1) begin
          rise_t.push_back(cyc);
          rise_d.push_back(tdata1);
        end
        prev1 = tvalid1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid0(input int limit, input string name);
    int n = 0;
    while (!tvalid0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!tvalid0) begin
      fails++;
      $display("FAIL %s: tvalid 0 after %0d cycles, expected 1", name, limit);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int c;
  int n0;
  int hold;

  initial begin
    rst = 1'b1; link_in = 1'b0; hpd_in = 1'b0; tready = 1'b1;
    cycles(3);
    check("in_reset_tvalid", 32'(tvalid0), 32'd0);
    check("in_reset_txcnt", 32'(cnt0), 32'd0);

    // Reset release: single beat 00, then silence.
    rst = 1'b0;
    cycles(1);
    check("first_beat_tvalid", 32'(tvalid0), 32'd1);
    check("first_beat_tdata", 32'(tdata0), 32'd0);
    cycles(109);
    check("after_reset_txcnt", 32'(cnt0), 32'd1);

    // Clean change on link ready.
    link_in = 1'b1;
    cycles(5);
    check("clean_cur_edge5", 32'(cur0), 32'd0);
    cycles(1);
    check("clean_cur_edge6", 32'(cur0), 32'd1);
    check("clean_tvalid_edge6", 32'(tvalid0), 32'd0);
    cycles(1);
    check("clean_tvalid_edge7", 32'(tvalid0), 32'd1);
    check("clean_tdata_edge7", 32'(tdata0), 32'd1);
    cycles(13);
    check("clean_txcnt", 32'(cnt0), 32'd2);

    // Glitch rejection with link ready low.
    link_in = 1'b0;
    cycles(20);
    hpd_in = 1'b1; cycles(3); hpd_in = 1'b0;
    cycles(20);
    check("glitch3_txcnt", 32'(cnt0), 32'd3);
    hpd_in = 1'b1; cycles(4); hpd_in = 1'b0;
    cycles(30);
    check("glitch4_txcnt", 32'(cnt0), 32'd5);

    // Backpressure: HPD rises while beat 01 is stalled.
    tready = 1'b0; link_in = 1'b1;
    wait_valid0(40, "bp_first_valid");
    cycles(3);
    hpd_in = 1'b1;
    cycles(47);
    check("bp_held_tdata", 32'(tdata0), 32'd1);
    tready = 1'b1;
    cycles(20);
    check("bp_txcnt", 32'(cnt0), 32'd7);

    // Refresh spacing on dut1 with stable inputs (11).
    cycles(30);
    rise_t.delete(); rise_d.delete();
    cycles(70);
    check("refresh_beats_seen", 32'(rise_t.size() >= 3), 32'd1);
    for (int i = 1; i < rise_t.size(); i++)
      check("refresh_gap", 32'(rise_t[i] - rise_t[i-1]), 32'(REFR + 1));
    for (int i = 0; i < rise_d.size(); i++)
      check("refresh_tdata", 32'(rise_d[i]), 32'd3);

    // Change landing on the same edge as refresh expiry: one beat only.
    n0 = rise_t.size();
    for (int i = 0; i < 40 && rise_t.size() == n0; i++) @(negedge clk);
    check("refresh_next_rise", 32'(rise_t.size() > n0), 32'd1);
    c = rise_t[rise_t.size()-1];
    while (cyc < c + 14) @(negedge clk);
    hpd_in = 1'b0;
    rise_t.delete(); rise_d.delete();
    while (cyc < c + 60) @(negedge clk);
    check("coincide_beats", 32'(rise_t.size()), 32'd2);
    if (rise_t.size() == 2) begin
      check("coincide_t0", 32'(rise_t[0] - c), 32'(REFR + 1));
      check("coincide_t1", 32'(rise_t[1] - c), 32'(2 * (REFR + 1)));
      check("coincide_d0", 32'(rise_d[0]), 32'd1);
      check("coincide_d1", 32'(rise_d[1]), 32'd1);
    end

    // Reset mid-beat.
    tready = 1'b0; hpd_in = 1'b1;
    wait_valid0(40, "rst_mid_valid");
    cycles(2);
    rst = 1'b1;
    #1;
    check("rst_abort_tvalid", 32'(tvalid0), 32'd0);
    check("rst_abort_tdata", 32'(tdata0), 32'd0);
    check("rst_abort_txcnt", 32'(cnt0), 32'd0);
    cycles(3);
    rst = 1'b0; tready = 1'b1;
    cycles(20);
    check("rst_rereport_txcnt", 32'(cnt0), 32'd2);

    // Randomised inputs and backpressure.
    for (int i = 0; i < 300; i++) begin
      link_in = 1'($urandom_range(0, 1));
      hpd_in  = 1'($urandom_range(0, 1));
      hold    = $urandom_range(1, 8);
      repeat (hold) begin
        tready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    end

    tready = 1'b1;
    cycles(40);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_txcnt", 32'(cnt0), 32'(m_count));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
